// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Miss handler for a direct-mapped write-back cache. When a lookup misses,
//   it first writes back a dirty victim line one word at a time. It then
//   refills the line from memory one word at a time. Finally it spends one
//   commit cycle before the held processor access is evaluated again.
//
//   The address is split as {tag, set index, word offset, 2'b00}.
//   TAG_WIDTH + SET_WIDTH + OFFSET_WIDTH must equal 32, and OFFSET_WIDTH
//   must be at least 3.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   en_i           processor access valid
//   write_en_i     access is a store
//   addr_i         processor byte address
//   hit_i          set lookup hit
//   dirty_i        victim line is dirty
//   tag_line_i     victim line tag
//   mem_ready_i    memory moves one word this cycle
//   stall_o        processor must hold the access
//   mem_req_o      memory word transfer requested
//   mem_write_o    transfer is a write-back
//   mem_addr_o     word-aligned memory address
//   offset_line_o  word index into the cache line
//   line_write_o   cache line word write enable
//   set_valid_o    mark line valid
//   set_dirty_o    mark line dirty
//   miss_count_o   misses since reset (wrapping)
module cache_refill_ctrl #(
  parameter int TAG_WIDTH    = 22,
  parameter int SET_WIDTH    = 4,
  parameter int OFFSET_WIDTH = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    write_en_i,
  input  logic [31:0]             addr_i,
  input  logic                    hit_i,
  input  logic                    dirty_i,
  input  logic [TAG_WIDTH-1:0]    tag_line_i,
  input  logic                    mem_ready_i,
  output logic                    stall_o,
  output logic                    mem_req_o,
  output logic                    mem_write_o,
  output logic [31:0]             mem_addr_o,
  output logic [OFFSET_WIDTH-3:0] offset_line_o,
  output logic                    line_write_o,
  output logic                    set_valid_o,
  output logic                    set_dirty_o,
  output logic [31:0]             miss_count_o
);

  localparam int CNT_W = OFFSET_WIDTH - 2;
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    READ_MEM   = 2'd2,
    COMMIT     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;    // tag of the missing access
  logic [SET_WIDTH-1:0]   idx_q, idx_d;    // set index of the missing access
  logic [TAG_WIDTH-1:0]   vtag_q, vtag_d;  // tag of the victim being written back
  logic [31:0]            miss_q, miss_d;

  // The byte-select bits never reach memory, because all transfers are word-aligned.
  logic unused_addr_s;
  assign unused_addr_s = ^addr_i[1:0];

  assign miss_count_o = miss_q;

  // Next-state, counter and output decode for the refill sequence
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    idx_d         = idx_q;
    vtag_d        = vtag_q;
    miss_d        = miss_q;
    stall_o       = 1'b0;
    mem_req_o     = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = {addr_i[31:2], 2'b00};
    offset_line_o = addr_i[OFFSET_WIDTH-1:2];
    line_write_o  = 1'b0;
    set_valid_o   = 1'b0;
    set_dirty_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i) begin
          if (hit_i) begin
            // A store hit updates the line in place and marks it dirty.
            if (write_en_i) begin
              line_write_o = 1'b1;
              set_valid_o  = 1'b1;
              set_dirty_o  = 1'b1;
            end else begin
              line_write_o = 1'b0;
            end
          end else begin
            // Capture everything the refill needs, so that later input
            // changes cannot disturb it.
            stall_o = 1'b1;
            tag_d   = addr_i[31 -: TAG_WIDTH];
            idx_d   = addr_i[OFFSET_WIDTH +: SET_WIDTH];
            vtag_d  = tag_line_i;
            cnt_d   = CNT_ZERO;
            miss_d  = miss_q + 32'd1;
            state_d = dirty_i ? WRITE_BACK : READ_MEM;
          end
        end else begin
          stall_o = 1'b0;
        end
      end

      WRITE_BACK: begin
        stall_o       = 1'b1;
        mem_req_o     = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = {vtag_q, idx_q, cnt_q, 2'b00};
        offset_line_o = cnt_q;
        if (mem_ready_i) begin
          // The counter wraps to zero on the last word, so the read phase starts at word 0.
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = READ_MEM;
          end else begin
            state_d = WRITE_BACK;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      READ_MEM: begin
        stall_o       = 1'b1;
        mem_req_o     = 1'b1;
        mem_addr_o    = {tag_q, idx_q, cnt_q, 2'b00};
        offset_line_o = cnt_q;
        line_write_o  = mem_ready_i;
        if (mem_ready_i) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // The last word lands now, so the line becomes valid and clean.
            set_valid_o = 1'b1;
            set_dirty_o = 1'b0;
            state_d     = COMMIT;
          end else begin
            state_d = READ_MEM;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      COMMIT: begin
        stall_o       = 1'b1;
        mem_addr_o    = {tag_q, idx_q, cnt_q, 2'b00};
        offset_line_o = cnt_q;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      tag_q   <= {TAG_WIDTH{1'b0}};
      idx_q   <= {SET_WIDTH{1'b0}};
      vtag_q  <= {TAG_WIDTH{1'b0}};
      miss_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      vtag_q  <= vtag_d;
      miss_q  <= miss_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with its default parameters.
// A transfer-queue model predicts every output on every cycle. Literal
// expectations from hand-worked examples pin the model itself.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, en_i, write_en_i, hit_i, dirty_i, mem_ready_i;
  logic [31:0] addr_i;
  logic [21:0] tag_line_i;
  logic        stall_o, mem_req_o, mem_write_o, line_write_o, set_valid_o, set_dirty_o;
  logic [31:0] mem_addr_o, miss_count_o;
  logic [3:0]  offset_line_o;

  cache_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .write_en_i(write_en_i),
    .addr_i(addr_i), .hit_i(hit_i), .dirty_i(dirty_i), .tag_line_i(tag_line_i),
    .mem_ready_i(mem_ready_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .offset_line_o(offset_line_o),
    .line_write_o(line_write_o), .set_valid_o(set_valid_o), .set_dirty_o(set_dirty_o),
    .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending refill is a queue of word transfers (kind 0 = write-back,
  // kind 1 = read) followed by a single commit marker (kind 2).
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] m_miss = 32'd0;

  // Model update at the clock edge, using the inputs held over the previous cycle
  always @(posedge clk) begin
    if (rst_i) begin
      q.delete();
      m_miss = 32'd0;
    end else if (q.size() == 0) begin
      if (en_i && !hit_i) begin
        m_miss = m_miss + 32'd1;
        if (dirty_i) begin
          for (int k = 0; k < 16; k++)
            q.push_back('{2'd0, {tag_line_i, addr_i[9:6], 6'd0} + 32'(k * 4)});
        end
        for (int k = 0; k < 16; k++)
          q.push_back('{2'd1, {addr_i[31:6], 6'd0} + 32'(k * 4)});
        q.push_back('{2'd2, 32'd0});
      end
    end else if (q[0].kind == 2'd2 || mem_ready_i) begin
      void'(q.pop_front());
    end
  end

  // Per-cycle comparison of the DUT against the model, sampled mid-cycle
  always @(negedge clk) begin
    logic e_stall, e_req, e_wr, e_lw, e_sv, e_sd, chk_addr;
    logic [31:0] e_addr;
    logic [3:0]  e_off;
    if (chk_en) begin
      e_stall = 1'b0; e_req = 1'b0; e_wr = 1'b0; e_lw = 1'b0; e_sv = 1'b0; e_sd = 1'b0;
      chk_addr = 1'b1;
      e_addr = {addr_i[31:2], 2'b00};
      e_off  = addr_i[5:2];
      if (q.size() == 0) begin
        if (en_i && hit_i && write_en_i) begin
          e_lw = 1'b1; e_sv = 1'b1; e_sd = 1'b1;
        end
        if (en_i && !hit_i) e_stall = 1'b1;
      end else if (q[0].kind == 2'd2) begin
        e_stall  = 1'b1;
        chk_addr = 1'b0;
      end else begin
        e_stall = 1'b1;
        e_req   = 1'b1;
        e_wr    = (q[0].kind == 2'd0);
        e_addr  = q[0].addr;
        e_off   = q[0].addr[5:2];
        if (q[0].kind == 2'd1) begin
          e_lw = mem_ready_i;
          e_sv = mem_ready_i && q.size() >= 2 && q[1].kind == 2'd2;
        end
      end
      chk("stall", 32'(stall_o), 32'(e_stall));
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      chk("mem_write", 32'(mem_write_o), 32'(e_wr));
      chk("line_write", 32'(line_write_o), 32'(e_lw));
      chk("set_valid", 32'(set_valid_o), 32'(e_sv));
      chk("set_dirty", 32'(set_dirty_o), 32'(e_sd));
      chk("miss_count", miss_count_o, m_miss);
      if (chk_addr) begin
        chk("mem_addr", mem_addr_o, e_addr);
        chk("offset_line", 32'(offset_line_o), 32'(e_off));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nstall, nw, nr, i;
    logic [31:0] first_rd, last_rd, first_wr;
    logic found;

    rst_i = 1'b1; en_i = 1'b0; write_en_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0;
    mem_ready_i = 1'b0; addr_i = 32'd0; tag_line_i = 22'd0;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_miss", miss_count_o, 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);

    // Read hit
    next_cycle();
    en_i = 1'b1; hit_i = 1'b1; write_en_i = 1'b0; addr_i = 32'h0000_0100;
    @(negedge clk);
    chk("rdhit_stall", 32'(stall_o), 32'd0);
    chk("rdhit_lw", 32'(line_write_o), 32'd0);
    chk("rdhit_miss", miss_count_o, 32'd0);

    // Write hit at 0x44
    next_cycle();
    write_en_i = 1'b1; addr_i = 32'h0000_0044;
    @(negedge clk);
    chk("wrhit_lw", 32'(line_write_o), 32'd1);
    chk("wrhit_sv", 32'(set_valid_o), 32'd1);
    chk("wrhit_sd", 32'(set_dirty_o), 32'd1);
    chk("wrhit_off", 32'(offset_line_o), 32'd1);

    // Clean miss, memory always ready
    next_cycle();
    write_en_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0; mem_ready_i = 1'b1;
    addr_i = 32'h1234_5680;
    @(negedge clk);
    chk("clean_miss_stall", 32'(stall_o), 32'd1);
    next_cycle();
    hit_i = 1'b1;
    nstall = 0; nr = 0; found = 1'b0; first_rd = 32'd0; last_rd = 32'd0;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        found = 1'b1;
        break;
      end
      nstall++;
      if (mem_req_o) begin
        if (nr == 0) first_rd = mem_addr_o;
        last_rd = mem_addr_o;
        nr++;
      end
    end
    chk("clean_done", 32'(found), 32'd1);
    chk("clean_stall_cycles", 32'(nstall), 32'd17);
    chk("clean_reads", 32'(nr), 32'd16);
    chk("clean_first_addr", first_rd, 32'h1234_5680);
    chk("clean_last_addr", last_rd, 32'h1234_56BC);
    chk("clean_miss_count", miss_count_o, 32'd1);

    // Dirty miss, ready toggling, inputs disturbed mid-read
    next_cycle();
    hit_i = 1'b0; dirty_i = 1'b1; tag_line_i = 22'h3; mem_ready_i = 1'b0;
    addr_i = 32'hABCD_E7C0;
    @(negedge clk);
    nw = 0; nr = 0; found = 1'b0; first_wr = 32'd0; last_rd = 32'd0;
    for (i = 0; i < 200; i++) begin
      next_cycle();
      hit_i = 1'b1; dirty_i = 1'b0;
      mem_ready_i = ~mem_ready_i;
      if (nr == 5) begin
        en_i = 1'b0; addr_i = 32'hDEAD_BEEC;
      end
      @(negedge clk);
      if (!stall_o) begin
        found = 1'b1;
        break;
      end
      if (mem_req_o && mem_ready_i) begin
        if (mem_write_o) begin
          if (nw == 0) first_wr = mem_addr_o;
          nw++;
        end else begin
          last_rd = mem_addr_o;
          nr++;
        end
      end
    end
    chk("dirty_done", 32'(found), 32'd1);
    chk("dirty_writes", 32'(nw), 32'd16);
    chk("dirty_reads", 32'(nr), 32'd16);
    chk("dirty_first_wr", first_wr, 32'h0000_0FC0);
    chk("dirty_last_rd", last_rd, 32'hABCD_E7FC);
    chk("dirty_miss_count", miss_count_o, 32'd2);

    // Reset in the middle of a refill, on the edge that ends word 7
    next_cycle();
    en_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b0; mem_ready_i = 1'b1; addr_i = 32'h0000_1000;
    @(negedge clk);
    next_cycle();
    hit_i = 1'b1;
    found = 1'b0;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req_o && !mem_write_o && offset_line_o == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_cnt7", 32'(found), 32'd1);
    #1 rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0; en_i = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_miss", miss_count_o, 32'd0);
    next_cycle();
    en_i = 1'b1; hit_i = 1'b0; addr_i = 32'h0000_2000;
    @(negedge clk);
    next_cycle();
    hit_i = 1'b1;
    @(negedge clk);
    chk("restart_addr", mem_addr_o, 32'h0000_2000);
    chk("restart_off", 32'(offset_line_o), 32'd0);
    chk("restart_miss", miss_count_o, 32'd1);
    found = 1'b0;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        found = 1'b1;
        break;
      end
    end
    chk("restart_done", 32'(found), 32'd1);

    next_cycle();
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 22, meaning the tag bits of the 32-bit address.
REQ-002 SHALL have parameter SET_WIDTH, default 4, meaning the set-index bits.
REQ-003 SHALL have parameter OFFSET_WIDTH, default 6, meaning the byte-offset bits; LINE_WORDS = 2**(OFFSET_WIDTH-2), default 16.
REQ-004 SHALL satisfy TAG_WIDTH+SET_WIDTH+OFFSET_WIDTH == 32, with OFFSET_WIDTH >= 3.
REQ-005 SHALL use one clock and a synchronous active-high reset: clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 en_i  in  1  processor access request valid.
REQ-008 write_en_i  in  1  access is a store.
REQ-009 addr_i  in  32  processor byte address.
REQ-010 hit_i  in  1  set lookup hit.
REQ-011 dirty_i  in  1  victim line dirty.
REQ-012 tag_line_i  in  TAG_WIDTH  victim line tag.
REQ-013 mem_ready_i  in  1  memory accepts or returns one word this cycle.
REQ-014 stall_o  out  1  processor must hold the access.
REQ-015 mem_req_o  out  1  memory word transfer requested.
REQ-016 mem_write_o  out  1  transfer is a write-back.
REQ-017 mem_addr_o  out  32  word-aligned memory address.
REQ-018 offset_line_o  out  OFFSET_WIDTH-2  line word index for the cache line.
REQ-019 line_write_o, set_valid_o, set_dirty_o  out  1 each  cache line write enable and valid/dirty updates.
REQ-020 miss_count_o  out  32  number of misses since reset.

Function
REQ-021 SHALL implement the states IDLE, WRITE_BACK, READ_MEM and COMMIT, and SHALL use a word counter cnt of width OFFSET_WIDTH-2.
REQ-022 In IDLE with en_i=0, SHALL drive all strobes to 0, hold stall_o=0, and set offset_line_o to addr_i[OFFSET_WIDTH-1:2].
REQ-023 In IDLE with en_i=1 and hit_i=1, SHALL hold stall_o=0, and SHALL assert line_write_o, set_valid_o and set_dirty_o combinationally when write_en_i=1.
REQ-024 In IDLE with en_i=1 and hit_i=0, SHALL assert stall_o combinationally and latch addr tag/index and tag_line_i.
REQ-025 On the same IDLE miss cycle, SHALL clear cnt, increment miss_count_o (wrapping), and go to WRITE_BACK if dirty_i=1, otherwise to READ_MEM.
REQ-026 In WRITE_BACK, SHALL assert mem_req_o=1, mem_write_o=1, stall_o=1, and drive mem_addr_o={latched victim tag, latched index, cnt, 2'b00}.
REQ-027 In READ_MEM, SHALL assert mem_req_o=1, mem_write_o=0, stall_o=1, drive mem_addr_o={latched tag, latched index, cnt, 2'b00}, and set line_write_o=mem_ready_i.
REQ-028 In WRITE_BACK and READ_MEM, SHALL set offset_line_o=cnt.
REQ-029 SHALL advance cnt only on cycles with mem_ready_i=1 and SHALL hold all outputs unchanged while mem_ready_i=0, with no timeout.
REQ-030 On WRITE_BACK with cnt==LINE_WORDS-1 and mem_ready_i=1, SHALL wrap cnt to 0 and go to READ_MEM.
REQ-031 On READ_MEM with cnt==LINE_WORDS-1 and mem_ready_i=1, SHALL assert set_valid_o=1 and set_dirty_o=0 in that cycle, wrap cnt to 0, and go to COMMIT.
REQ-032 COMMIT SHALL last exactly one cycle with stall_o=1 and all memory strobes at 0, then go to IDLE, where the held access re-evaluates as a hit.
REQ-033 Once a refill starts, SHALL complete it regardless of en_i, addr_i or write_en_i changes; mid-refill input changes SHALL be ignored.
REQ-034 mem_addr_o in IDLE SHALL be {addr_i[31:OFFSET_WIDTH], addr_i[OFFSET_WIDTH-1:2], 2'b00}.

Reset
REQ-035 On rst_i=1 at a clock edge, SHALL go to IDLE and clear cnt, the latched tag/index and miss_count_o, including mid-refill; the next cycle's outputs SHALL be the IDLE values.
REQ-036 rst_i SHALL take priority over all other inputs.

Verification
REQ-037 Read hit: en_i=1, hit_i=1, write_en_i=0 -> stall_o=0, no strobes, miss_count_o stays 0.
REQ-038 Write hit at 0x0000_0044 -> line_write_o=set_valid_o=set_dirty_o=1 in the same cycle and offset_line_o=1.
REQ-039 Clean miss at 0x1234_5680, mem_ready_i=1 constantly -> 16 READ_MEM cycles with addresses 0x1234_5680..0x1234_56BC, then 1 COMMIT cycle, stall_o high for 17 cycles after the miss cycle, and miss_count_o=1.
REQ-040 Dirty miss with tag_line_i=0x3 and mem_ready_i toggling 1/0 -> 16 writes to {0x3, index, cnt, 00} each held while ready=0, then 16 reads, with cnt advancing only on ready.
REQ-041 rst_i asserted at READ_MEM cnt=7 -> next cycle IDLE, mem_req_o=0, miss_count_o=0, and a later miss restarts at cnt=0.
REQ-042 en_i dropped and addr_i changed mid-READ_MEM -> refill completes to the originally latched address.
